loader_wr_fifo: RTL and testbench
=================================

Name: loader_wr_fifo

Overview:
- Write buffer between the ROM loader and the SDRAM controller's write port during cartridge download.
- Captures single-cycle loader byte writes (address and data) into a small FIFO.
- Drains one entry per SDRAM write slot; the slot is the existing 1-in-4 nes_ce strobe.
- Prevents byte loss when loader writes arrive closer together than write slots. Reports busy so the top can hold the download reset until the buffer has drained.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries).
- AW, 22, address width of the loader address space.

Ports:
- clk  in  1  system clock (NES core clock domain).
- reset  in  1  synchronous, active-high.
- in_we  in  1  loader write strobe, one cycle per byte.
- in_addr  in  AW  loader byte address.
- in_data  in  8  loader byte data.
- slot  in  1  SDRAM write-slot strobe, one cycle wide, at most once every 2 cycles.
- out_we  out  1  write request to SDRAM, held for a full slot period.
- out_addr  out  AW  address presented with out_we.
- out_data  out  8  data presented with out_we.
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  DEPTH_LOG2+1  current entry count.
- busy  out  1  (!empty) | out_we.
- overflow  out  1  sticky; a write was dropped.

Behaviour:
- Reset, synchronous, active-high on clk:
  - read and write pointers = 0, level = 0, empty = 1, full = 0.
  - out_we = 0, out_addr = 0, out_data = 0, overflow = 0.
  - FIFO contents are not cleared.
  - Reset wins over every simultaneous in_we and slot.
- Storage:
  - Circular buffer of {addr, data}.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - level is the registered count; full = (level == 2^DEPTH_LOG2); empty = (level == 0).
- Push: in_we && (!full || pop) writes {in_addr, in_data} at wptr. wptr increments.
- Pop: slot && !empty.
  - Head entry is registered into out_addr/out_data; out_we <= 1; rptr increments.
- Slot with FIFO empty: out_we <= 0; out_addr/out_data hold their last values.
- out_we timing:
  - Changes only on slot cycles or reset.
  - Each popped entry is presented for exactly one slot period, from the cycle after slot up to and including the next slot cycle.
- Latency: an entry pushed into an empty FIFO appears on out_* one cycle after the first slot that occurs at least one cycle after the push.
  - A push and a slot in the same cycle on an empty FIFO: the slot sees empty, so no pop.
  - Entries are never read combinationally through.
- Simultaneous push and pop:
  - level unchanged.
  - Allowed when full: the pop frees the slot, so the push is accepted.
- Overflow: in_we && full && !pop drops the byte, sets overflow = 1, and leaves the pointers and level unchanged. overflow clears only on reset.
- Order: strict FIFO; the addr/data pairing is never split.
- Arithmetic: level += push - pop, with width DEPTH_LOG2+1; it never exceeds depth or goes below 0.
- Reset mid-drain: pending entries are discarded and out_we drops on the next cycle. The caller must restart the download.

Test Plan:
- Single byte: reset, then in_we with addr=0x000010 data=0xA5; slot 3 cycles later → out_we=1 with out_addr=0x000010, out_data=0xA5 from the cycle after slot; at the next slot with the FIFO empty, out_we=0; busy goes 1→1→0.
- Burst fill: 8 consecutive in_we (addr 0..7, data 0x10..0x17) with no slot → level=8, full=1, overflow=0. A 9th write (addr 8) → overflow=1, level stays 8. Then 8 slots every 4 cycles → out sequence addr 0..7, data 0x10..0x17 in order; empty=1 at the end.
- Push+pop at full: FIFO full, in_we (addr 0x200000, data 0x5A) in the same cycle as slot → level stays 8, overflow stays 0; 0x200000/0x5A emerges 8 pops later.
- Wrap-around: 20 writes, each spaced 5 cycles, with slots every 4 cycles → all 20 bytes emerge in order, pointers wrap twice, overflow=0, level never exceeds 2.
- Same-cycle push and slot on empty FIFO: in_we at cycle t with slot at t → no pop at t, out_we stays 0; the next slot pops the byte.
- Reset mid-drain: 5 entries queued with out_we=1; assert reset for 1 cycle → next cycle out_we=0, level=0, empty=1, overflow=0, busy=0; subsequent slots produce no writes.

Source files
------------

// File: rtl/loader_wr_fifo_if.sv
// Loader-to-SDRAM write buffer bus. The master drives loader writes and the slot strobe.
// The slave (the FIFO) returns the SDRAM write request and the buffer status.
interface loader_wr_fifo_if #(
    parameter int DEPTH_LOG2 = 3,
    parameter int AW         = 22
);
    logic                  in_we;
    logic [AW-1:0]         in_addr;
    logic [7:0]            in_data;
    logic                  slot;
    logic                  out_we;
    logic [AW-1:0]         out_addr;
    logic [7:0]            out_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  busy;
    logic                  overflow;

    modport master (
        output in_we, in_addr, in_data, slot,
        input  out_we, out_addr, out_data, full, empty, level, busy, overflow
    );

    modport slave (
        input  in_we, in_addr, in_data, slot,
        output out_we, out_addr, out_data, full, empty, level, busy, overflow
    );
endinterface

// File: rtl/loader_wr_fifo.sv
// Buffers single-cycle loader byte writes and replays them one per SDRAM write slot.
// busy stays high until the last entry has had its full slot period on out_*.
module loader_wr_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int AW         = 22
) (
    input  logic               clk,
    input  logic               reset,
    loader_wr_fifo_if.slave    bus
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [AW+7:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  out_we_q, out_we_d;
    logic [AW-1:0]         out_addr_q, out_addr_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  overflow_q, overflow_d;
    logic                  full, empty, push, pop;

    always_comb begin
        full  = (level_q == DEPTH_CNT);
        empty = (level_q == '0);
        pop   = bus.slot && !empty;
        // A pop in the same cycle frees a slot, so a write at full is still accepted.
        push  = bus.in_we && (!full || pop);
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        out_we_d   = out_we_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;

        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end else if (bus.in_we) begin
            overflow_d = 1'b1;
        end

        if (bus.slot) begin
            out_we_d = pop;
        end
        if (pop) begin
            {out_addr_d, out_data_d} = mem_q[rptr_q];
            rptr_d = rptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left uninitialised across reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= {bus.in_addr, bus.in_data};
        end
    end

    assign bus.out_we   = out_we_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_data = out_data_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level_q;
    assign bus.busy     = !empty || out_we_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_loader_wr_fifo.sv
// Directed and random stimulus for loader_wr_fifo, checked every cycle against a queue model.
module tb_loader_wr_fifo;
    localparam int DL    = 3;
    localparam int AW    = 22;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    loader_wr_fifo_if #(.DEPTH_LOG2(DL), .AW(AW)) bus ();
    loader_wr_fifo #(.DEPTH_LOG2(DL), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference: queue of {addr,data} plus the presented output word.
    logic [AW+7:0] mq[$];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    logic          m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                              input logic sl, input logic rst);
        bit popping, was_full;
        if (rst) begin
            mq.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        popping  = sl && (mq.size() != 0);
        if (popping) begin
            {m_addr, m_data} = mq.pop_front();
            m_we = 1'b1;
        end else if (sl) begin
            m_we = 1'b0;
        end
        if (we) begin
            if (!was_full || popping) mq.push_back({a, d});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        check("out_we",   32'(bus.out_we),   32'(m_we));
        check("out_addr", 32'(bus.out_addr), 32'(m_addr));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("level",    32'(bus.level),    32'(mq.size()));
        check("full",     32'(bus.full),     32'(mq.size() == DEPTH));
        check("empty",    32'(bus.empty),    32'(mq.size() == 0));
        check("busy",     32'(bus.busy),     32'((mq.size() != 0) || m_we));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                       input logic sl, input logic rst = 1'b0);
        bus.in_we = we; bus.in_addr = a; bus.in_data = d; bus.slot = sl; reset = rst;
        @(posedge clk);
        model_step(we, a, d, sl, rst);
        #1;
        check_all();
        bus.in_we = 1'b0; bus.slot = 1'b0; reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic prev_sl;
        bus.in_we = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.slot = 1'b0; reset = 1'b1;
        m_we = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;

        // Reset, with a write and slot colliding to confirm reset wins.
        cyc(1'b1, 22'h3, 8'h33, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        check("rst_empty", 32'(bus.empty), 32'd1);

        // Single byte: slot three cycles after the push.
        cyc(1'b1, 22'h000010, 8'hA5, 1'b0);
        check("sb_busy0", 32'(bus.busy), 32'd1);
        idle(2);
        cyc(1'b0, '0, '0, 1'b1);
        check("sb_we", 32'(bus.out_we), 32'd1);
        check("sb_addr", 32'(bus.out_addr), 32'h10);
        check("sb_data", 32'(bus.out_data), 32'hA5);
        check("sb_busy1", 32'(bus.busy), 32'd1);
        idle(3);
        cyc(1'b0, '0, '0, 1'b1);
        check("sb_we_off", 32'(bus.out_we), 32'd0);
        check("sb_busy2", 32'(bus.busy), 32'd0);
        check("sb_hold", 32'(bus.out_data), 32'hA5);

        // Burst fill then one write too many.
        for (int i = 0; i < 8; i++) cyc(1'b1, 22'(i), 8'(8'h10 + i), 1'b0);
        check("bf_level", 32'(bus.level), 32'd8);
        check("bf_full", 32'(bus.full), 32'd1);
        check("bf_ovf0", 32'(bus.overflow), 32'd0);
        cyc(1'b1, 22'h8, 8'h18, 1'b0);
        check("bf_ovf1", 32'(bus.overflow), 32'd1);
        check("bf_level2", 32'(bus.level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, '0, 1'b1);
            check("bf_addr", 32'(bus.out_addr), 32'(i));
            check("bf_data", 32'(bus.out_data), 32'(8'h10 + i));
            idle(3);
        end
        check("bf_empty", 32'(bus.empty), 32'd1);

        // Push and pop together while full.
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 22'(8'h40 + i), 8'(i), 1'b0);
        cyc(1'b1, 22'h200000, 8'h5A, 1'b1);
        check("pf_level", 32'(bus.level), 32'd8);
        check("pf_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin idle(3); cyc(1'b0, '0, '0, 1'b1); end
        check("pf_addr", 32'(bus.out_addr), 32'h200000);
        check("pf_data", 32'(bus.out_data), 32'h5A);
        idle(3); cyc(1'b0, '0, '0, 1'b1);

        // Wrap-around: writes every 5 cycles, slots every 4.
        for (int c = 0; c < 110; c++) begin
            cyc((c % 5 == 0) && (c / 5 < 20), 22'(22'h1000 + c), 8'(c * 7), (c % 4) == 1);
            check("wr_lvl", 32'(bus.level <= 2), 32'd1);
        end
        check("wr_ovf", 32'(bus.overflow), 32'd0);

        // Same-cycle push and slot on an empty FIFO.
        idle(2);
        cyc(1'b1, 22'h0ABCDE, 8'hC3, 1'b1);
        check("sc_we", 32'(bus.out_we), 32'd0);
        idle(1);
        cyc(1'b0, '0, '0, 1'b1);
        check("sc_addr", 32'(bus.out_addr), 32'h0ABCDE);

        // Reset mid-drain.
        for (int i = 0; i < 6; i++) cyc(1'b1, 22'(22'h300 + i), 8'(i), 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        check("rm_we1", 32'(bus.out_we), 32'd1);
        cyc(1'b1, 22'h3FF, 8'hFF, 1'b1, 1'b1);
        check("rm_we0", 32'(bus.out_we), 32'd0);
        check("rm_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin idle(1); cyc(1'b0, '0, '0, 1'b1); end
        check("rm_we_post", 32'(bus.out_we), 32'd0);

        // Random traffic, slot never on consecutive cycles.
        prev_sl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic sl;
            sl = !prev_sl && ($urandom_range(0, 2) == 0);
            cyc(1'($urandom_range(0, 1)), 22'($urandom), 8'($urandom), sl,
                1'($urandom_range(0, 299) == 0));
            prev_sl = sl;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
